pipelined_barrel_shifter: RTL

Parametrised, fully pipelined logarithmic barrel shifter for the datapath ALU. Supports logical-left, logical-right and arithmetic-right shifts, with rotate as an option. Uses one register stage per shift bit and a valid/ready handshake with whole-pipe stall. It is the registered, multi-mode successor to the single-mode combinational 32-bit left shifter, and feeds the ALU result mux.

---
 rtl/shifter_pkg.sv | 19 +
 rtl/pipelined_barrel_shifter_stage.sv | 79 +++++++
 rtl/pipelined_barrel_shifter.sv | 82 ++++++++
 3 files changed

// File: rtl/shifter_pkg.sv
// -----------------------------------------------------------------------------
// shifter_pkg
// Shared types and constants for the pipelined barrel shifter.
//   shift_op_t          : operation carried alongside each operand.
//   SHIFTER_DEFAULT_N   : default data width.
// Optional feature macro: SHIFTER_ROTATE_EN (see shift_stage).
// -----------------------------------------------------------------------------
package shifter_pkg;

  typedef enum logic [1:0] {
    SHIFT_SLL = 2'd0,
    SHIFT_SRL = 2'd1,
    SHIFT_SRA = 2'd2,
    SHIFT_ROL = 2'd3
  } shift_op_t;

  localparam int SHIFTER_DEFAULT_N = 32;

endpackage

// File: rtl/pipelined_barrel_shifter_stage.sv
// -----------------------------------------------------------------------------
// shift_stage
// One level of the logarithmic shifter: conditionally shifts the incoming word
// by 2^STAGE_IDX (when shamt bit STAGE_IDX is set) according to the op, then
// registers data, shamt, op and valid when en is high.
// Ports:
//   clk, rst           : clock, synchronous active-high reset
//   en                 : pipeline advance; all registers hold when low
//   valid_in/valid_out : valid bit travelling with the operand
//   data_in/data_out   : N-bit word before/after this stage
//   shamt_in/shamt_out : shift amount travelling with the operand
//   op_in/op_out       : operation travelling with the operand
// Optional feature macro: SHIFTER_ROTATE_EN -- when defined, SHIFT_ROL rotates
// left; otherwise SHIFT_ROL is treated as SHIFT_SLL and no rotate mux exists.
// -----------------------------------------------------------------------------
module shift_stage
  import shifter_pkg::*;
#(
  parameter int N         = SHIFTER_DEFAULT_N,
  parameter int STAGE_IDX = 0,
  parameter int LOG2N     = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             valid_in,
  input  logic [N-1:0]     data_in,
  input  logic [LOG2N-1:0] shamt_in,
  input  shift_op_t        op_in,
  output logic             valid_out,
  output logic [N-1:0]     data_out,
  output logic [LOG2N-1:0] shamt_out,
  output shift_op_t        op_out
);

  localparam int S = 1 << STAGE_IDX;

  logic [N-1:0]     data_next;
  logic             valid_reg;
  logic [N-1:0]     data_reg;
  logic [LOG2N-1:0] shamt_reg;
  shift_op_t        op_reg;

  always_comb begin
    data_next = data_in;
    if (shamt_in[STAGE_IDX]) begin
      case (op_in)
        SHIFT_SRL: data_next = data_in >> S;
        // The MSB is never altered by an arithmetic shift, so replicating the
        // current MSB at every stage reproduces the original sign.
        SHIFT_SRA: data_next = {{S{data_in[N-1]}}, data_in[N-1:S]};
`ifdef SHIFTER_ROTATE_EN
        SHIFT_ROL: data_next = {data_in[N-1-S:0], data_in[N-1:N-S]};
`endif
        default:   data_next = data_in << S;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_reg <= 1'b0;
      data_reg  <= '0;
      shamt_reg <= '0;
      op_reg    <= SHIFT_SLL;
    end else if (en) begin
      valid_reg <= valid_in;
      data_reg  <= data_next;
      shamt_reg <= shamt_in;
      op_reg    <= op_in;
    end
  end

  assign valid_out = valid_reg;
  assign data_out  = data_reg;
  assign shamt_out = shamt_reg;
  assign op_out    = op_reg;

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// -----------------------------------------------------------------------------
// pipelined_barrel_shifter
// Fully pipelined logarithmic barrel shifter (SLL/SRL/SRA, optional ROL) with
// one register stage per shamt bit and a whole-pipe stall handshake.
// Latency is LOG2N cycles; throughput one result per cycle.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_ready   : operand handshake (in_ready = pipeline advance)
//   in_data             : N-bit operand
//   in_shamt            : shift amount 0..N-1
//   in_op               : shift_op_t encoding (SLL=0, SRL=1, SRA=2, ROL=3)
//   out_valid/out_ready : result handshake
//   out_data            : shifted result
// Optional feature macro: SHIFTER_ROTATE_EN enables ROL (op=3); otherwise op=3
// behaves as SLL.
// -----------------------------------------------------------------------------
module pipelined_barrel_shifter
  import shifter_pkg::*;
#(
  parameter  int N     = SHIFTER_DEFAULT_N,
  localparam int LOG2N = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_data,
  input  logic [LOG2N-1:0] in_shamt,
  input  logic [1:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_data
);

  // Element k is the input of stage k; element LOG2N is the pipeline output.
  logic             valid_chain [0:LOG2N];
  logic [N-1:0]     data_chain  [0:LOG2N];
  logic [LOG2N-1:0] shamt_chain [0:LOG2N];
  shift_op_t        op_chain    [0:LOG2N];

  // Whole-pipe stall: everything moves together or nothing moves, so bubbles
  // stay in place and ordering is trivially preserved.
  logic advance;
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  assign valid_chain[0] = in_valid;
  assign data_chain[0]  = in_data;
  assign shamt_chain[0] = in_shamt;
  assign op_chain[0]    = shift_op_t'(in_op);

  genvar gi;
  generate
    for (gi = 0; gi < LOG2N; gi++) begin : g_stage
      shift_stage #(
        .N         (N),
        .STAGE_IDX (gi),
        .LOG2N     (LOG2N)
      ) u_stage (
        .clk       (clk),
        .rst       (rst),
        .en        (advance),
        .valid_in  (valid_chain[gi]),
        .data_in   (data_chain[gi]),
        .shamt_in  (shamt_chain[gi]),
        .op_in     (op_chain[gi]),
        .valid_out (valid_chain[gi+1]),
        .data_out  (data_chain[gi+1]),
        .shamt_out (shamt_chain[gi+1]),
        .op_out    (op_chain[gi+1])
      );
    end
  endgenerate

  assign out_valid = valid_chain[LOG2N];
  assign out_data  = data_chain[LOG2N];

  // The final shamt/op copies have no consumer.
  logic unused_tail;
  assign unused_tail = ^{shamt_chain[LOG2N], op_chain[LOG2N]};

endmodule
